scratchpad_mem_bb: RTL and testbench
====================================

# scratchpad_mem_bb

Parametrised single-port scratchpad memory for RoCC accelerators, the successor to the fixed 1024×64 blackbox memory. It adds a decoupled valid/ready request and response interface with tags, byte-masked writes, out-of-range error reporting, and a 2-entry response buffer, so the accelerator control FSM can apply backpressure without losing read data. It sits between the accelerator datapath and its local storage and is instantiated from Chisel as a BlackBox.

## Interface
- DATA_W, 64, data width in bits; must be a multiple of 8
- ADDR_W, 10, address width in bits
- DEPTH, 1024, number of implemented words; 1 ≤ DEPTH ≤ 2^ADDR_W
- TAG_W, 5, request/response tag width
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted
- req_wren  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wrdata  in  DATA_W  write data
- req_mask  in  DATA_W/8  byte write enables; bit i covers bits [8i+7:8i]
- req_tag  in  TAG_W  returned unchanged on the response
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rddata  out  DATA_W  read data; 0 for writes and errors
- resp_tag  out  TAG_W  tag of the originating request
- resp_wr  out  1  response belongs to a write
- resp_err  out  1  req_addr ≥ DEPTH

## Operation
- Handshakes: the request fires when req_valid && req_ready, and the response fires when resp_valid && resp_ready. Every fired request produces exactly one response, in request order.
- Response buffer: 2-entry FIFO with occupancy count occ in 0..2. req_ready = (occ < 2). It depends only on registered state and has no combinational path from resp_ready.
- Read fire: the entry captures {mem[req_addr], req_tag, wr=0, err=0}. This is the array contents before any write in the same cycle; only one request per cycle exists, so there is no intra-cycle conflict.
- Write fire: for each i with req_mask[i]=1, byte i of mem[req_addr] ← byte i of req_wrdata. Other bytes are unchanged. The entry captures {0, req_tag, wr=1, err=0}. A mask of all zeros is legal; it writes nothing and still produces a response.
- Out-of-range fire (req_addr ≥ DEPTH): there is no array access and the write is suppressed. The entry is {0, req_tag, wr=req_wren, err=1}.
- The resp_* outputs always present the FIFO head. When occ=0 they hold 0.
- Simultaneous push and pop: occ is unchanged and ordering is preserved.
- Memory contents are never initialised or cleared, including by reset.

## Timing
- Reset: occ=0, req_ready=1 in the first cycle after reset, resp_valid=0, and resp_rddata, resp_tag, resp_wr, resp_err all 0. Buffered responses are discarded. Any request presented in the reset cycle is ignored, with no write and no response.
- Latency: a request fired at edge T gives resp_valid=1 in the cycle after T, provided the buffer was empty or drains first.
- Read-after-write: a read fired at T+1 to an address written at T returns the new data.
- Throughput: with resp_ready held at 1, one request per cycle is sustained indefinitely (occ stays at 1).
- Backpressure: with resp_ready=0, two requests are accepted, then req_ready=0. req_ready returns to 1 in the cycle after the first response fires.
- resp_valid and the head data stay stable while resp_valid && !resp_ready.

## Test plan
- Reset then idle: assert reset for 2 cycles with req_valid=1 and req_wren=1. Required: no response appears, req_ready=1, resp_valid=0, and all resp_* outputs are 0.
- Masked write and read-back: write addr 5 with 0xFFFF_FFFF_FFFF_FFFF and mask 0xFF, then write addr 5 with 0x1122_3344_5566_7788 and mask 0x0F, then read addr 5 (tag 3). Required: resp_rddata=0xFFFF_FFFF_5566_7788, resp_tag=3, resp_wr=0, resp_err=0.
- Back-to-back streaming: write addrs 0..15 with data=addr×3, then issue 16 consecutive reads with resp_ready=1. Required: req_ready stays 1, and responses arrive one per cycle at 1-cycle latency, in order, with data 0,3,…,45.
- Backpressure: hold resp_ready=0 and offer reads with tags 1, 2, 3. Required: tags 1 and 2 accepted, then req_ready=0. Set resp_ready=1. Required: responses come out with tags 1, 2, 3 in order, and no data is lost or duplicated.
- Out-of-range (DEPTH=1000): write addr 1000 with 0xDEAD and mask 0xFF, then read addr 1000 and addr 999. Required: the first two responses have err=1 and rddata=0; the addr 999 read returns its prior contents, unaffected by the rejected write.
- Reset mid-operation: with 2 buffered responses, assert reset for 1 cycle. Required: afterwards occ=0, resp_valid=0, and a following read returns data written before the reset.

Source files
------------

// File: rtl/scratchpad_mem_bb_if.sv
// Request/response bundle of the scratchpad: tagged valid/ready request in, tagged valid/ready response out.
// Both channels transfer on a rising clock edge where valid && ready; valid never waits on ready.
interface scratchpad_mem_bb_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned TAG_W  = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wren;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wrdata;
    logic [DATA_W/8-1:0]   req_mask;
    logic [TAG_W-1:0]      req_tag;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rddata;
    logic [TAG_W-1:0]      resp_tag;
    logic                  resp_wr;
    logic                  resp_err;

    modport master (
        output req_valid, req_wren, req_addr, req_wrdata, req_mask, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_rddata, resp_tag, resp_wr, resp_err
    );

    modport slave (
        input  req_valid, req_wren, req_addr, req_wrdata, req_mask, req_tag, resp_ready,
        output req_ready, resp_valid, resp_rddata, resp_tag, resp_wr, resp_err
    );
endinterface

// File: rtl/scratchpad_mem_bb.sv
// Single-port scratchpad with byte-masked writes, out-of-range error flagging and a
// 2-entry in-order response buffer so the consumer can stall without losing read data.
module scratchpad_mem_bb #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned TAG_W  = 5
) (
    input  logic               clock,
    input  logic               reset,
    scratchpad_mem_bb_if.slave bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] r_ent_data [2];
    logic [TAG_W-1:0]  r_ent_tag  [2];
    logic              r_ent_wr   [2];
    logic              r_ent_err  [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_occ;

    logic              w_push;
    logic              w_pop;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic              w_head_valid;

    // Ready depends only on occupancy, never on resp_ready.
    assign bus.req_ready = (r_occ != 2'd2);
    assign w_head_valid  = (r_occ != 2'd0);
    assign w_push        = bus.req_valid && bus.req_ready;
    assign w_pop         = w_head_valid && bus.resp_ready;
    assign w_in_range    = ({1'b0, bus.req_addr} < DEPTH_L);
    assign w_idx         = bus.req_addr[IDX_W-1:0];

    // Array has no reset: contents survive reset; writes are blocked during it.
    always_ff @(posedge clock) begin
        if (!reset && w_push && bus.req_wren && w_in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.req_wrdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_occ  <= 2'd0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_ent_data[r_wptr] <= (w_in_range && !bus.req_wren) ? r_mem[w_idx] : '0;
                r_ent_tag[r_wptr]  <= bus.req_tag;
                r_ent_wr[r_wptr]   <= bus.req_wren;
                r_ent_err[r_wptr]  <= !w_in_range;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Head entry is masked to zero while the buffer is empty.
    assign bus.resp_valid  = w_head_valid;
    assign bus.resp_rddata = w_head_valid ? r_ent_data[r_rptr] : '0;
    assign bus.resp_tag    = w_head_valid ? r_ent_tag[r_rptr]  : '0;
    assign bus.resp_wr     = w_head_valid ? r_ent_wr[r_rptr]   : 1'b0;
    assign bus.resp_err    = w_head_valid ? r_ent_err[r_rptr]  : 1'b0;
endmodule

// File: tb/tb_scratchpad_mem_bb.sv
// Directed bench for scratchpad_mem_bb (DEPTH=1000): reset, masked writes, streaming,
// backpressure, out-of-range and mid-operation reset, with an in-order response scoreboard.
module tb_scratchpad_mem_bb;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;
    localparam int TAG_W  = 5;
    localparam int EW     = 1 + 1 + TAG_W + DATA_W;

    logic clk;
    logic reset;

    scratchpad_mem_bb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

    scratchpad_mem_bb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: expected entries are {err, wr, tag, data}
    logic [EW-1:0] exp_q[$];
    int            cyc_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            stalls   = 0;
    logic          lat_chk  = 1'b0;
    logic [EW-1:0] mon_exp;
    int            mon_fc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // response monitor: every response that fires must match the head of exp_q
    always @(negedge clk) begin
        if (!reset && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", {bus.resp_err, bus.resp_wr, bus.resp_tag, bus.resp_rddata}, '0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_fc  = cyc_q.pop_front();
                check("resp", {bus.resp_err, bus.resp_wr, bus.resp_tag, bus.resp_rddata}, mon_exp);
                if (lat_chk) check("resp_latency", cyc - mon_fc, 0);
            end
        end
    end

    // driver tasks
    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic issue(input logic wren, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic [7:0] mask,
                         input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] exp_data,
                         input logic exp_err);
        int   waits;
        logic fired;
        bus.req_valid  = 1'b1;
        bus.req_wren   = wren;
        bus.req_addr   = addr;
        bus.req_wrdata = data;
        bus.req_mask   = mask;
        bus.req_tag    = tag;
        waits = 0;
        fired = 1'b0;
        while (!fired && waits < 20) begin
            @(negedge clk);
            fired = bus.req_ready;
            if (!fired) begin
                waits++;
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!fired) check("req_timeout", fired, 1);
        else begin
            exp_q.push_back({exp_err, wren, tag, exp_data});
            cyc_q.push_back(cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // reset with a write request held: must be ignored
        reset          = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_wren   = 1'b1;
        bus.req_addr   = 10'd3;
        bus.req_wrdata = 64'h1234;
        bus.req_mask   = 8'hFF;
        bus.req_tag    = 5'd9;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        @(negedge clk);
        check("rst_req_ready",  bus.req_ready,   1);
        check("rst_resp_valid", bus.resp_valid,  0);
        check("rst_rddata",     bus.resp_rddata, 0);
        check("rst_tag",        bus.resp_tag,    0);
        check("rst_wr",         bus.resp_wr,     0);
        check("rst_err",        bus.resp_err,    0);
        @(posedge clk);
        #1;

        // masked write then read-back
        issue(1'b1, 10'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 5'd1, 64'h0, 1'b0);
        issue(1'b1, 10'd5, 64'h1122_3344_5566_7788, 8'h0F, 5'd2, 64'h0, 1'b0);
        issue(1'b0, 10'd5, 64'h0, 8'h00, 5'd3, 64'hFFFF_FFFF_5566_7788, 1'b0);
        idle();
        wait_cycles(3);

        // streaming writes then reads at one per cycle
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 10'(i), 64'(i * 3), 8'hFF, 5'(i), 64'h0, 1'b0);
        end
        stalls  = 0;
        lat_chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 10'(i), 64'h0, 8'h00, 5'(i + 16), 64'(i * 3), 1'b0);
        end
        idle();
        wait_cycles(3);
        lat_chk = 1'b0;
        check("stream_no_stall", stalls, 0);
        check("stream_drained", exp_q.size(), 0);

        // backpressure: two accepted, third held off until first response fires
        bus.resp_ready = 1'b0;
        issue(1'b0, 10'd0, 64'h0, 8'h00, 5'd1, 64'd0, 1'b0);
        issue(1'b0, 10'd1, 64'h0, 8'h00, 5'd2, 64'd3, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_wren  = 1'b0;
        bus.req_addr  = 10'd2;
        bus.req_mask  = 8'h00;
        bus.req_tag   = 5'd3;
        @(negedge clk);
        check("bp_ready_low", bus.req_ready, 0);
        check("bp_head_tag",  bus.resp_tag,  1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_head_hold_valid", bus.resp_valid, 1);
        check("bp_head_hold_tag",   bus.resp_tag,   1);
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_still_low", bus.req_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_ready_back", bus.req_ready, 1);
        exp_q.push_back({1'b0, 1'b0, 5'd3, 64'd6});
        cyc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        idle();
        wait_cycles(4);
        check("bp_drained", exp_q.size(), 0);

        // out-of-range
        issue(1'b1, 10'd999,  64'h999,  8'hFF, 5'd7,  64'h0,   1'b0);
        issue(1'b1, 10'd1000, 64'hDEAD, 8'hFF, 5'd8,  64'h0,   1'b1);
        issue(1'b0, 10'd1000, 64'h0,    8'h00, 5'd9,  64'h0,   1'b1);
        issue(1'b0, 10'd999,  64'h0,    8'h00, 5'd10, 64'h999, 1'b0);
        issue(1'b1, 10'd12,   64'hAA,   8'h00, 5'd11, 64'h0,   1'b0);
        issue(1'b0, 10'd12,   64'h0,    8'h00, 5'd12, 64'd36,  1'b0);
        idle();
        wait_cycles(3);
        check("oor_drained", exp_q.size(), 0);

        // reset with two buffered responses
        bus.resp_ready = 1'b0;
        issue(1'b1, 10'd7, 64'hABCD, 8'hFF, 5'd4, 64'h0,    1'b0);
        issue(1'b0, 10'd7, 64'h0,    8'h00, 5'd5, 64'hABCD, 1'b0);
        idle();
        @(negedge clk);
        check("mid_full", bus.req_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        @(negedge clk);
        check("mid_resp_valid", bus.resp_valid,  0);
        check("mid_req_ready",  bus.req_ready,   1);
        check("mid_rddata",     bus.resp_rddata, 0);
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        issue(1'b0, 10'd7, 64'h0, 8'h00, 5'd6, 64'hABCD, 1'b0);
        idle();
        wait_cycles(4);
        check("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
